snake_tile_map: RTL and testbench

Tile-map store that sits directly upstream of the VGA sprite renderer. It holds one 4-bit sprite code per 16×16 tile of the 640×480 screen (40×30 tiles). The HPS writes codes over the Avalon slave through a small pending-write FIFO. The FIFO drains only during vertical blank, so a frame never tears. The renderer looks up the code for the current tile through a registered read port.

---
 rtl/snake_tile_map.sv | 162 ++++++++++++++++
 tb/tb_snake_tile_map.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/snake_tile_map.sv
// snake_tile_map: 40x30 sprite-code tile map. HPS writes are queued in a small FIFO
// that drains only during vblank; the renderer reads through a one-cycle registered port.
module snake_tile_map #(
  parameter int FIFO_DEPTH = 4,
  parameter int MAP_W      = 40,
  parameter int MAP_H      = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       chipselect,
  input  logic       write,
  input  logic       read,
  input  logic [2:0] address,
  input  logic [7:0] writedata,
  output logic [7:0] readdata,
  input  logic       vblank,
  input  logic [5:0] rd_tx,
  input  logic [4:0] rd_ty,
  output logic [3:0] rd_code
);

  localparam int PW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW    = PW + 1;
  localparam int MAP_N = MAP_W * MAP_H;
  localparam logic [10:0]   LAST_ADDR = 11'(MAP_N - 1);
  localparam logic [5:0]    MAP_W6    = 6'(MAP_W);
  localparam logic [4:0]    MAP_H5    = 5'(MAP_H);
  localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  function automatic logic [10:0] tile_addr(input logic [5:0] tx, input logic [4:0] ty);
    return 11'(ty) * 11'(MAP_W) + 11'(tx);
  endfunction

  state_t        state_q, state_d;
  logic [10:0]   clr_addr_q, clr_addr_d;
  logic [5:0]    tile_x_q;
  logic [4:0]    tile_y_q;
  logic [3:0]    code_q;
  logic          ovf_q;
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [7:0]    readdata_q, rdata_d;
  logic [3:0]    rd_code_q;

  logic [14:0]   fifo_mem [FIFO_DEPTH];
  logic [3:0]    map_mem  [MAP_N];

  logic        wr_en, rd_en, push_req, clr_req, ovf_clr, ovf_set;
  logic        fifo_full, fifo_empty, push, pop, busy;
  logic [14:0] head;
  logic        pop_in_range, rd_in_range;
  logic [10:0] rd_addr;
  logic        ram_we;
  logic [10:0] ram_wa;
  logic [3:0]  ram_wd;
  logic        unused_wd;

  assign wr_en      = chipselect & write;
  assign rd_en      = chipselect & read;
  assign push_req   = wr_en && (address == 3'd2);
  assign clr_req    = wr_en && (address == 3'd3) && writedata[0];
  assign ovf_clr    = wr_en && (address == 3'd3) && writedata[1];
  assign fifo_full  = (count_q == FULL_CNT);
  assign fifo_empty = (count_q == '0);
  assign busy       = (state_q == S_CLEAR);
  assign pop        = !busy && vblank && !fifo_empty;
  // A pop frees a slot in the same cycle, so a push into a full FIFO still lands.
  assign push       = push_req && (!fifo_full || pop);
  assign ovf_set    = push_req && fifo_full && !pop;
  assign head       = fifo_mem[rd_ptr_q];
  assign pop_in_range = (head[14:9] < MAP_W6) && (head[8:4] < MAP_H5);
  assign rd_in_range  = (rd_tx < MAP_W6) && (rd_ty < MAP_H5);
  assign rd_addr      = tile_addr(rd_tx, rd_ty);
  assign unused_wd    = &{1'b0, writedata[7:6]};

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    case (state_q)
      S_IDLE: begin
        if (clr_req) begin
          state_d    = S_CLEAR;
          clr_addr_d = '0;
        end
      end
      S_CLEAR: begin
        if (clr_req)                       clr_addr_d = '0;
        else if (clr_addr_q == LAST_ADDR)  state_d    = S_IDLE;
        else                               clr_addr_d = clr_addr_q + 11'd1;
      end
      default: state_d = S_CLEAR;
    endcase
  end

  always_comb begin
    ram_we = 1'b0;
    ram_wa = clr_addr_q;
    ram_wd = 4'd0;
    if (busy) begin
      ram_we = !reset;
    end else if (pop && pop_in_range) begin
      ram_we = !reset;
      ram_wa = tile_addr(head[14:9], head[8:4]);
      ram_wd = head[3:0];
    end
  end

  always_comb begin
    rdata_d = 8'd0;
    case (address)
      3'd0:    rdata_d = {2'b0, tile_x_q};
      3'd1:    rdata_d = {3'b0, tile_y_q};
      3'd2:    rdata_d = {4'b0, code_q};
      3'd3:    rdata_d = {3'b0, 3'(count_q), ovf_q, busy};
      default: rdata_d = 8'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (ram_we) map_mem[ram_wa] <= ram_wd;
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= {tile_x_q, tile_y_q, writedata[3:0]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_CLEAR;
      clr_addr_q <= '0;
      tile_x_q   <= '0;
      tile_y_q   <= '0;
      code_q     <= '0;
      ovf_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      readdata_q <= '0;
      rd_code_q  <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      if (wr_en && address == 3'd0) tile_x_q <= writedata[5:0];
      if (wr_en && address == 3'd1) tile_y_q <= writedata[4:0];
      if (push_req)                 code_q   <= writedata[3:0];
      if (ovf_clr)      ovf_q <= 1'b0;
      else if (ovf_set) ovf_q <= 1'b1;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CW'(push) - CW'(pop);
      if (rd_en) readdata_q <= rdata_d;
      // Same-edge RAM write is not forwarded: the renderer sees the old code this cycle.
      rd_code_q <= rd_in_range ? map_mem[rd_addr] : 4'd0;
    end
  end

  assign readdata = readdata_q;
  assign rd_code  = rd_code_q;

endmodule

// File: tb/tb_snake_tile_map.sv
// Self-checking bench for snake_tile_map: queue-based reference model compared every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_snake_tile_map;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset, chipselect, write, read, vblank;
  logic [2:0] address;
  logic [7:0] writedata, readdata;
  logic [5:0] rd_tx;
  logic [4:0] rd_ty;
  logic [3:0] rd_code;

  always #5 clk = ~clk;

  snake_tile_map #(.FIFO_DEPTH(DEPTH), .MAP_W(40), .MAP_H(30)) dut (
    .clk(clk), .reset(reset), .chipselect(chipselect), .write(write), .read(read),
    .address(address), .writedata(writedata), .readdata(readdata), .vblank(vblank),
    .rd_tx(rd_tx), .rd_ty(rd_ty), .rd_code(rd_code)
  );

  int n_pass = 0;
  int n_total = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference model: map entries are -1 until something known has been written.
  typedef struct {int x; int y; int c;} ent_t;
  ent_t mq[$];
  ent_t e;
  int   mmap[1200];
  int   m_tx, m_ty, m_code, m_ovf, clr_pos, exp_rd, exp_rdata;
  bit   m_busy, m_pop, m_clr;

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 1200; i++) mmap[i] = -1;
      mq.delete();
      m_tx = 0; m_ty = 0; m_code = 0; m_ovf = 0;
      clr_pos = 0; exp_rd = 0; exp_rdata = 0;
    end else begin
      m_busy = (clr_pos >= 0);
      m_clr  = 1'b0;
      if (rd_tx < 40 && rd_ty < 30) exp_rd = mmap[rd_ty * 40 + rd_tx];
      else exp_rd = 0;
      if (chipselect && read) begin
        case (address)
          3'd0: exp_rdata = m_tx;
          3'd1: exp_rdata = m_ty;
          3'd2: exp_rdata = m_code;
          3'd3: exp_rdata = ((mq.size() & 7) << 2) | (m_ovf << 1) | int'(m_busy);
          default: exp_rdata = 0;
        endcase
      end
      m_pop = !m_busy && vblank && (mq.size() > 0);
      if (m_pop) begin
        e = mq.pop_front();
        if (e.x < 40 && e.y < 30) mmap[e.y * 40 + e.x] = e.c;
      end
      if (chipselect && write) begin
        case (address)
          3'd0: m_tx = writedata & 63;
          3'd1: m_ty = writedata & 31;
          3'd2: begin
            m_code = writedata & 15;
            if (mq.size() < DEPTH) begin
              e.x = m_tx; e.y = m_ty; e.c = m_code;
              mq.push_back(e);
            end else m_ovf = 1;
          end
          3'd3: begin
            if (writedata[1]) m_ovf = 0;
            if (writedata[0]) m_clr = 1'b1;
          end
          default: ;
        endcase
      end
      if (m_busy) begin
        mmap[clr_pos] = 0;
        if (m_clr) clr_pos = 0;
        else if (clr_pos == 1199) clr_pos = -1;
        else clr_pos++;
      end else if (m_clr) clr_pos = 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("readdata", int'(readdata), exp_rdata);
      if (exp_rd >= 0) chk("rd_code", int'(rd_code), exp_rd);
    end
  end

  task automatic av_write(input int a, input int d);
    chipselect = 1'b1; write = 1'b1; read = 1'b0;
    address = 3'(a); writedata = 8'(d);
    @(negedge clk);
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic av_read(input int a, output int v);
    chipselect = 1'b1; read = 1'b1; write = 1'b0; address = 3'(a);
    @(negedge clk);
    chipselect = 1'b0; read = 1'b0;
    v = int'(readdata);
  endtask

  task automatic lookup(input int x, input int y, output int c);
    rd_tx = 6'(x); rd_ty = 5'(y);
    @(negedge clk);
    c = int'(rd_code);
  endtask

  initial begin
    int n, v, c, a, d;
    reset = 1'b1; chipselect = 1'b0; write = 1'b0; read = 1'b0; vblank = 1'b0;
    address = '0; writedata = '0; rd_tx = '0; rd_ty = '0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;

    // Power-up clear: busy for exactly 1200 cycles.
    reset = 1'b0; chipselect = 1'b1; read = 1'b1; address = 3'd3;
    n = 0;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if (readdata[0]) n++; else break;
    end
    chipselect = 1'b0; read = 1'b0;
    chk("reset_busy_cycles", n, 1200);
    lookup(39, 29, c); chk("post_reset_39_29", c, 0);

    // Single queued write, drained on vblank.
    vblank = 1'b0;
    av_write(0, 5); av_write(1, 10); av_write(2, 7);
    av_read(3, v); chk("status_count1", v, 8'h04);
    lookup(5, 10, c); chk("held_5_10", c, 0);
    vblank = 1'b1;
    @(negedge clk); chk("drain_edge_old_code", int'(rd_code), 0);
    @(negedge clk); chk("after_drain_5_10", int'(rd_code), 7);
    av_read(3, v); chk("status_drained", v, 8'h00);

    // Overflow: fifth push dropped, four land in push order.
    vblank = 1'b0;
    av_write(1, 1);
    av_write(0, 1); av_write(2, 1);
    av_write(0, 2); av_write(2, 2);
    av_write(0, 1); av_write(2, 3);
    av_write(0, 3); av_write(2, 4);
    av_write(0, 4); av_write(2, 5);
    av_read(3, v); chk("status_full_ovf", v, 8'h12);
    av_write(3, 2);
    av_read(3, v); chk("status_ovf_cleared", v, 8'h10);
    vblank = 1'b1;
    repeat (6) @(negedge clk);
    lookup(1, 1, c); chk("order_1_1", c, 3);
    lookup(2, 1, c); chk("order_2_1", c, 2);
    lookup(3, 1, c); chk("order_3_1", c, 4);
    lookup(4, 1, c); chk("dropped_4_1", c, 0);
    lookup(41, 0, c); chk("lookup_x_oob", c, 0);
    lookup(1, 30, c); chk("lookup_y_oob", c, 0);

    // Push into a full FIFO on the same cycle as a pop.
    vblank = 1'b0;
    av_write(0, 6); av_write(1, 2);
    for (int i = 1; i <= 4; i++) av_write(2, i);
    vblank = 1'b1;
    av_write(2, 5); av_write(2, 6); av_write(2, 7);
    vblank = 1'b0;
    av_read(3, v); chk("full_push_pop_status", v, 8'h10);
    vblank = 1'b1;
    repeat (6) @(negedge clk);
    lookup(6, 2, c); chk("full_push_pop_last", c, 7);

    // Out-of-range entry is popped but must not alias onto address 160.
    av_write(0, 0); av_write(1, 4); av_write(2, 11);
    repeat (3) @(negedge clk);
    lookup(0, 4, c); chk("tile_0_4_set", c, 11);
    vblank = 1'b0;
    av_write(0, 40); av_write(1, 3); av_write(2, 5);
    av_read(3, v); chk("oob_queued", v, 8'h04);
    vblank = 1'b1;
    repeat (3) @(negedge clk);
    av_read(3, v); chk("oob_popped", v, 8'h00);
    lookup(0, 4, c); chk("oob_no_alias", c, 11);

    // Clear, re-requested at cycle 600; pushes made during the clear stay queued.
    vblank = 1'b0;
    av_write(0, 7); av_write(1, 7);
    av_write(3, 1);
    n = 0;
    for (int i = 1; i <= 2100; i++) begin
      chipselect = 1'b1; write = 1'b0; read = 1'b1; address = 3'd3; writedata = 8'h00;
      if (i == 600) begin write = 1'b1; writedata = 8'h01; end
      if (i == 100 || i == 101) begin
        write = 1'b1; read = 1'b0; address = 3'd2;
        writedata = (i == 100) ? 8'd9 : 8'd10;
      end
      @(negedge clk);
      if (readdata[0]) n++; else break;
    end
    chipselect = 1'b0; write = 1'b0; read = 1'b0;
    chk("rerequest_busy_cycles", n, 1800);
    av_read(3, v); chk("clear_pending_pushes", v, 8'h08);
    for (int ty = 0; ty < 30; ty++)
      for (int tx = 0; tx < 40; tx++) begin
        lookup(tx, ty, c);
        chk("cleared_tile", c, 0);
      end
    vblank = 1'b1;
    repeat (4) @(negedge clk);
    lookup(7, 7, c); chk("post_clear_drain", c, 10);

    // Randomized traffic against the model.
    for (int i = 0; i < 6000; i++) begin
      reset = ($urandom % 2500 == 0);
      chipselect = ($urandom % 4 != 0);
      write = $urandom % 2;
      read = $urandom % 2;
      a = ($urandom % 4 == 0) ? int'($urandom % 8) : int'($urandom % 4);
      d = int'($urandom % 256);
      if (a == 3 && ($urandom % 200) != 0) d = d & 8'hFE;
      address = 3'(a); writedata = 8'(d);
      if ($urandom % 20 == 0) vblank = ~vblank;
      rd_tx = 6'($urandom % 64);
      rd_ty = 5'($urandom % 32);
      @(negedge clk);
    end
    reset = 1'b0; chipselect = 1'b0; write = 1'b0; read = 1'b0;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
